rotation_parser: RTL

ROTATION_PARSER -- requirements
Module: rotation_parser

---
 rtl/rotation_parser_pkg.sv | 30 +++
 rtl/rotation_parser_if.sv | 25 ++
 rtl/rotation_parser_dec_accum.sv | 25 ++
 rtl/rotation_parser.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/rotation_parser_pkg.sv
// Shared definitions for the rotation record parser: ASCII codes, FSM states and defaults.
package rotation_parser_pkg;

  localparam int unsigned W_DEFAULT = 32;

  localparam logic [7:0] ChL    = 8'h4C;
  localparam logic [7:0] ChR    = 8'h52;
  localparam logic [7:0] ChLf   = 8'h0A;
  localparam logic [7:0] ChCr   = 8'h0D;
  localparam logic [7:0] ChNul  = 8'h00;
  localparam logic [7:0] ChEot  = 8'h04;
  localparam logic [7:0] ChZero = 8'h30;
  localparam logic [7:0] ChNine = 8'h39;

  typedef enum logic [1:0] {
    StIdle,
    StDigits,
    StSkip,
    StFin
  } state_e;

  function automatic logic is_end(logic [7:0] b);
    return (b == ChNul) || (b == ChEot);
  endfunction

  function automatic logic is_digit(logic [7:0] b);
    return (b >= ChZero) && (b <= ChNine);
  endfunction

endpackage

// File: rtl/rotation_parser_if.sv
// Byte-stream input and signed-record output handshakes of the rotation parser.
interface rotation_parser_if
  import rotation_parser_pkg::*;
#(
  parameter int unsigned W = W_DEFAULT
) ();

  logic         in_valid;
  logic [7:0]   in_data;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] out_n;
  logic         out_ready;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_n
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_n
  );

endinterface

// File: rtl/rotation_parser_dec_accum.sv
// Decimal accumulate step: acc*10 + digit, clamped to the all-ones accumulator value.
module dec_accum #(
  parameter int unsigned AW = 31
) (
  input  logic [AW-1:0] acc_i,
  input  logic [3:0]    digit_i,
  output logic [AW-1:0] acc_o,
  output logic          sat_o
);

  // Four guard bits hold acc*10+9 for any AW-bit acc.
  localparam int unsigned XW = AW + 4;
  localparam logic [XW-1:0] MaxVal = {4'b0000, {AW{1'b1}}};

  logic [XW-1:0] acc_x;
  logic [XW-1:0] wide;

  always_comb begin
    acc_x = {4'b0000, acc_i};
    wide  = (acc_x << 3) + (acc_x << 1) + {{AW{1'b0}}, digit_i};
    sat_o = wide > MaxVal;
    acc_o = sat_o ? {AW{1'b1}} : wide[AW-1:0];
  end

endmodule

// File: rtl/rotation_parser.sv
// Parses "L<n>\n" / "R<n>\n" ASCII lines into signed rotation records with a single
// bubble-free output register, sticky done/err flags and a record counter.
module rotation_parser
  import rotation_parser_pkg::*;
#(
  parameter int unsigned W  = W_DEFAULT,
  parameter int unsigned CW = 16
) (
  input  logic          clk,
  input  logic          reset,
  rotation_parser_if.slave bus,
  output logic          done,
  output logic          err,
  output logic [CW-1:0] rec_count
);

  state_e        state_q, state_d;
  logic [W-2:0]  acc_q, acc_d;
  logic          dir_q, dir_d;     // 1 = 'L'
  logic          seen_q, seen_d;
  logic          out_valid_q, out_valid_d;
  logic [W-1:0]  out_n_q, out_n_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic          in_ready;
  logic          accept;
  logic          emit;
  logic [7:0]    b;
  logic [W-2:0]  acc_nxt;
  logic          acc_sat;
  logic [W-1:0]  mag;

  dec_accum #(
    .AW (W - 1)
  ) u_dec_accum (
    .acc_i   (acc_q),
    .digit_i (bus.in_data[3:0]),
    .acc_o   (acc_nxt),
    .sat_o   (acc_sat)
  );

  // A pending record being consumed this cycle frees the register for a new one.
  assign in_ready = !(out_valid_q && !bus.out_ready) && (state_q != StFin);
  assign accept   = bus.in_valid && in_ready;
  assign b        = bus.in_data;
  assign mag      = {1'b0, acc_q};

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    dir_d       = dir_q;
    seen_d      = seen_q;
    out_valid_d = out_valid_q;
    out_n_d     = out_n_q;
    done_d      = done_q;
    err_d       = err_q;
    cnt_d       = cnt_q;
    emit        = 1'b0;

    if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
      cnt_d       = cnt_q + CW'(1);
    end

    if (accept) begin
      unique case (state_q)
        StIdle: begin
          if (b == ChL || b == ChR) begin
            state_d = StDigits;
            dir_d   = (b == ChL);
            acc_d   = '0;
            seen_d  = 1'b0;
          end else if (b == ChLf || b == ChCr) begin
            state_d = StIdle;
          end else if (is_end(b)) begin
            state_d = StFin;
          end else begin
            err_d   = 1'b1;
            state_d = StSkip;
          end
        end
        StDigits: begin
          if (is_digit(b)) begin
            acc_d  = acc_nxt;
            seen_d = 1'b1;
            if (acc_sat) err_d = 1'b1;
          end else if (b == ChCr) begin
            state_d = StDigits;
          end else if (b == ChLf || is_end(b)) begin
            if (seen_q) emit = 1'b1;
            else        err_d = 1'b1;
            state_d = (b == ChLf) ? StIdle : StFin;
          end else begin
            err_d   = 1'b1;
            state_d = StSkip;
          end
        end
        StSkip: begin
          if (b == ChLf)     state_d = StIdle;
          else if (is_end(b)) state_d = StFin;
        end
        StFin: state_d = StFin;
      endcase
    end

    if (emit) begin
      out_valid_d = 1'b1;
      out_n_d     = dir_q ? ('0 - mag) : mag;
    end

    if (state_q == StFin && !out_valid_q) done_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      acc_q       <= '0;
      dir_q       <= 1'b0;
      seen_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_n_q     <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      dir_q       <= dir_d;
      seen_q      <= seen_d;
      out_valid_q <= out_valid_d;
      out_n_q     <= out_n_d;
      done_q      <= done_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_n     = out_n_q;
  assign done          = done_q;
  assign err           = err_q;
  assign rec_count     = cnt_q;

endmodule
